register_port_arbiter: RTL and testbench

//  Shares the register-file write port and a spare read port between CPU writeback and a debug/monitor

---
 rtl/register_port_arbiter_pkg.sv | 16 +
 rtl/register_port_arbiter.sv | 108 ++++++++++
 tb/tb_register_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_port_arbiter_pkg.sv
// Shared constants for the register-file port arbiter: widths, the hard-wired
// zero register index and the arbiter state encoding.
package register_port_arbiter_pkg;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;
   localparam int STATE_W = 2;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] ST_PEND  = 2'd1;
   localparam logic [STATE_W-1:0] ST_STALL = 2'd2;
   localparam logic [STATE_W-1:0] ST_ACK   = 2'd3;

endpackage

// File: rtl/register_port_arbiter.sv
// Arbitrates the register-file write port and spare read port between CPU
// writeback (zero-latency priority) and a req/ack debug requester.
module register_port_arbiter
   import register_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int MAX_WAIT   = 8
) (
   input  logic                  iCpuClock,
   input  logic                  iCpuReset,
   input  logic                  iCpuWrEn,
   input  logic [ADDR_WIDTH-1:0] iCpuWrAddr,
   input  logic [DATA_WIDTH-1:0] iCpuWrData,
   input  logic                  iDbgReq,
   input  logic                  iDbgWrite,
   input  logic [ADDR_WIDTH-1:0] iDbgAddr,
   input  logic [DATA_WIDTH-1:0] iDbgWData,
   output logic                  oDbgAck,
   output logic [DATA_WIDTH-1:0] oDbgRData,
   output logic                  oCpuStall,
   output logic                  oRfWrEn,
   output logic [ADDR_WIDTH-1:0] oRfWrAddr,
   output logic [DATA_WIDTH-1:0] oRfWrData,
   output logic [ADDR_WIDTH-1:0] oRfRdAddr,
   input  logic [DATA_WIDTH-1:0] iRfRdData
);

   localparam int CNT_W = $clog2(MAX_WAIT) + 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

   logic [STATE_W-1:0]    state, stateNext;
   logic [CNT_W-1:0]      waitCnt;
   logic                  latWrite;
   logic [ADDR_WIDTH-1:0] latAddr;
   logic [DATA_WIDTH-1:0] latWData;

   logic addrIsZero;
   logic blocked;
   logic granted;
   logic dbgWrIssue;

   assign addrIsZero = (latAddr == ADDR_WIDTH'(REG_ZERO));

   // A debug read only conflicts with a CPU write to the very register it reads.
   assign blocked    = latWrite ? iCpuWrEn
                                : (iCpuWrEn && (iCpuWrAddr == latAddr) && !addrIsZero);
   assign granted    = ((state == ST_PEND) || (state == ST_STALL)) && !blocked;
   assign dbgWrIssue = granted && latWrite && !addrIsZero;
   assign oRfRdAddr  = latAddr;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE:  if (iDbgReq) stateNext = ST_PEND;
         ST_PEND: begin
            if (granted)                   stateNext = ST_ACK;
            else if (waitCnt == WAIT_LAST) stateNext = ST_STALL;
         end
         ST_STALL: if (granted)  stateNext = ST_ACK;
         ST_ACK:   if (!iDbgReq) stateNext = ST_IDLE;
         default:                stateNext = ST_IDLE;
      endcase
   end

   always_comb begin
      oRfWrEn   = iCpuWrEn;
      oRfWrAddr = iCpuWrAddr;
      oRfWrData = iCpuWrData;
      if (dbgWrIssue) begin
         oRfWrEn   = 1'b1;
         oRfWrAddr = latAddr;
         oRfWrData = latWData;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iCpuClock or negedge iCpuReset) begin
      if (!iCpuReset) begin
         state     <= ST_IDLE;
         waitCnt   <= '0;
         latWrite  <= 1'b0;
         latAddr   <= '0;
         latWData  <= '0;
         oDbgRData <= '0;
         oDbgAck   <= 1'b0;
         oCpuStall <= 1'b0;
      end else begin
         state     <= stateNext;
         oDbgAck   <= (stateNext == ST_ACK);
         oCpuStall <= (stateNext == ST_STALL);

         if ((state == ST_IDLE) && iDbgReq) begin
            latWrite <= iDbgWrite;
            latAddr  <= iDbgAddr;
            latWData <= iDbgWData;
            waitCnt  <= '0;
         end else if ((state == ST_PEND) && blocked && (waitCnt != WAIT_LAST)) begin
            waitCnt  <= waitCnt + CNT_W'(1);
         end

         if (granted && !latWrite)
            oDbgRData <= addrIsZero ? '0 : iRfRdData;
      end
   end

endmodule

// File: tb/tb_register_port_arbiter.sv
// Directed bench for register_port_arbiter: table-driven write-port vectors
// plus hand sequences for starvation, read hazards and reset abort.
module tb_register_port_arbiter;

   logic        iCpuClock = 1'b0;
   logic        iCpuReset;
   logic        iCpuWrEn;
   logic [4:0]  iCpuWrAddr;
   logic [31:0] iCpuWrData;
   logic        iDbgReq;
   logic        iDbgWrite;
   logic [4:0]  iDbgAddr;
   logic [31:0] iDbgWData;
   logic        oDbgAck;
   logic [31:0] oDbgRData;
   logic        oCpuStall;
   logic        oRfWrEn;
   logic [4:0]  oRfWrAddr;
   logic [31:0] oRfWrData;
   logic [4:0]  oRfRdAddr;
   logic [31:0] iRfRdData;

   int nChecks = 0;
   int nFails  = 0;

   register_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MAX_WAIT(8)) dut (
      .iCpuClock (iCpuClock),
      .iCpuReset (iCpuReset),
      .iCpuWrEn  (iCpuWrEn),
      .iCpuWrAddr(iCpuWrAddr),
      .iCpuWrData(iCpuWrData),
      .iDbgReq   (iDbgReq),
      .iDbgWrite (iDbgWrite),
      .iDbgAddr  (iDbgAddr),
      .iDbgWData (iDbgWData),
      .oDbgAck   (oDbgAck),
      .oDbgRData (oDbgRData),
      .oCpuStall (oCpuStall),
      .oRfWrEn   (oRfWrEn),
      .oRfWrAddr (oRfWrAddr),
      .oRfWrData (oRfWrData),
      .oRfRdAddr (oRfRdAddr),
      .iRfRdData (iRfRdData)
   );

   always #5 iCpuClock = ~iCpuClock;

   // Register-file model; entry i powers up as 0x100+i, including entry 0,
   // so a debug read of r0 must be forced to zero by the arbiter.
   logic [31:0] rf [32];
   always @(posedge iCpuClock or negedge iCpuReset) begin
      if (!iCpuReset) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + i;
      end else if (oRfWrEn && (oRfWrAddr != 5'd0)) begin
         rf[oRfWrAddr] <= oRfWrData;
      end
   end
   assign iRfRdData = rf[oRfRdAddr];

   typedef struct packed {
      logic        cpuEn;
      logic [4:0]  cpuAddr;
      logic [31:0] cpuData;
      logic        req;
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic        expWrEn;
      logic [4:0]  expWrAddr;
      logic [31:0] expWrData;
      logic        expAck;
      logic        expStall;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge iCpuClock);
      #1;
   endtask

   task automatic drive(input logic cEn, input logic [4:0] cAddr, input logic [31:0] cData,
                        input logic req, input logic wr, input logic [4:0] addr,
                        input logic [31:0] wdata);
      iCpuWrEn   = cEn;
      iCpuWrAddr = cAddr;
      iCpuWrData = cData;
      iDbgReq    = req;
      iDbgWrite  = wr;
      iDbgAddr   = addr;
      iDbgWData  = wdata;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // cpu{en,addr,data} dbg{req,wr,addr,wdata} exp{wrEn,wrAddr,wrData,ack,stall}
      // Debug write r5 with an idle CPU.
      vecs[0]  = '{1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
      vecs[1]  = '{1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
      vecs[3]  = '{1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
      vecs[4]  = '{1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
      vecs[5]  = '{1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
      // CPU writes r1..r3 back to back while a debug write to r9 waits.
      vecs[6]  = '{1'b1, 5'd1, 32'h11, 1'b1, 1'b1, 5'd9, 32'h99,       1'b1, 5'd1, 32'h11,       1'b0, 1'b0};
      vecs[7]  = '{1'b1, 5'd2, 32'h22, 1'b1, 1'b1, 5'd9, 32'h99,       1'b1, 5'd2, 32'h22,       1'b0, 1'b0};
      vecs[8]  = '{1'b1, 5'd3, 32'h33, 1'b1, 1'b1, 5'd9, 32'h99,       1'b1, 5'd3, 32'h33,       1'b0, 1'b0};
      vecs[9]  = '{1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd9, 32'h99,       1'b1, 5'd9, 32'h99,       1'b0, 1'b0};
      vecs[10] = '{1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
      vecs[11] = '{1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
      vecs[12] = '{1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
      // Debug write r0: acked but never reaches the write port.
      vecs[13] = '{1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
      vecs[14] = '{1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
      vecs[15] = '{1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
      vecs[16] = '{1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
      // Request dropped before ack: write still issued, ack shown for one cycle.
      vecs[17] = '{1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
      vecs[18] = '{1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd4, 32'h44,       1'b1, 5'd4, 32'h44,       1'b0, 1'b0};
      vecs[19] = '{1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
      vecs[20] = '{1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,        1'b0, 1'b0};

      iCpuReset = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      step();
      step();
      check("reset oDbgAck",   32'(oDbgAck),   32'h0);
      check("reset oCpuStall", 32'(oCpuStall), 32'h0);
      check("reset oDbgRData", oDbgRData,      32'h0);
      check("reset oRfRdAddr", 32'(oRfRdAddr), 32'h0);
      check("reset oRfWrEn",   32'(oRfWrEn),   32'h0);
      iCpuReset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         step();
         drive(vecs[i].cpuEn, vecs[i].cpuAddr, vecs[i].cpuData,
               vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         #1;
         check($sformatf("v%0d oRfWrEn", i),   32'(oRfWrEn),   32'(vecs[i].expWrEn));
         check($sformatf("v%0d oRfWrAddr", i), 32'(oRfWrAddr), 32'(vecs[i].expWrAddr));
         check($sformatf("v%0d oRfWrData", i), oRfWrData,      vecs[i].expWrData);
         check($sformatf("v%0d oDbgAck", i),   32'(oDbgAck),   32'(vecs[i].expAck));
         check($sformatf("v%0d oCpuStall", i), 32'(oCpuStall), 32'(vecs[i].expStall));
      end

      // Starvation: CPU writes every cycle, stall rises after MAX_WAIT blocked cycles.
      step();
      drive(1'b1, 5'd1, 32'h1000, 1'b1, 1'b1, 5'd10, 32'hA5A5);
      for (int k = 0; k < 8; k++) begin
         step();
         drive(1'b1, 5'd1, 32'h1001 + k, 1'b1, 1'b1, 5'd10, 32'hA5A5);
         #1;
         check($sformatf("starve%0d oCpuStall", k), 32'(oCpuStall), 32'h0);
         check($sformatf("starve%0d oRfWrData", k), oRfWrData,      32'h1001 + k);
         check($sformatf("starve%0d oDbgAck", k),   32'(oDbgAck),   32'h0);
      end
      for (int k = 0; k < 2; k++) begin
         step();
         drive(1'b1, 5'd2, 32'h2000 + k, 1'b1, 1'b1, 5'd10, 32'hA5A5);
         #1;
         check($sformatf("stall%0d oCpuStall", k), 32'(oCpuStall), 32'h1);
         check($sformatf("stall%0d oRfWrAddr", k), 32'(oRfWrAddr), 32'h2);
         check($sformatf("stall%0d oRfWrData", k), oRfWrData,      32'h2000 + k);
      end
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd10, 32'hA5A5);
      #1;
      check("stall grant oRfWrEn",   32'(oRfWrEn),   32'h1);
      check("stall grant oRfWrAddr", 32'(oRfWrAddr), 32'd10);
      check("stall grant oRfWrData", oRfWrData,      32'hA5A5);
      check("stall grant oCpuStall", 32'(oCpuStall), 32'h1);
      step();
      #1;
      check("stall ack oCpuStall", 32'(oCpuStall), 32'h0);
      check("stall ack oDbgAck",   32'(oDbgAck),   32'h1);
      check("stall ack oRfWrEn",   32'(oRfWrEn),   32'h0);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd10, 32'hA5A5);
      step();
      #1;
      check("stall done oDbgAck", 32'(oDbgAck), 32'h0);

      // Read r7 held by a CPU write to r7, then returns the new value.
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd7, 32'h0);
      step();
      drive(1'b1, 5'd7, 32'h1234, 1'b1, 1'b0, 5'd7, 32'h0);
      #1;
      check("rd7 oRfRdAddr", 32'(oRfRdAddr), 32'd7);
      check("rd7 oRfWrAddr", 32'(oRfWrAddr), 32'd7);
      check("rd7 oRfWrData", oRfWrData,      32'h1234);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd7, 32'h0);
      #1;
      check("rd7 held oDbgAck", 32'(oDbgAck), 32'h0);
      step();
      #1;
      check("rd7 oDbgAck",   32'(oDbgAck), 32'h1);
      check("rd7 oDbgRData", oDbgRData,    32'h1234);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd7, 32'h0);
      step();
      step();

      // Read r0 while the CPU targets r0: not held, returns zero.
      drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
      step();
      drive(1'b1, 5'd0, 32'h7777, 1'b1, 1'b0, 5'd0, 32'h0);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
      #1;
      check("rd0 oDbgAck",   32'(oDbgAck), 32'h1);
      check("rd0 oDbgRData", oDbgRData,    32'h0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      step();
      step();

      // Read r8 while the CPU writes r7: no hazard, captured at once.
      drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd8, 32'h0);
      step();
      drive(1'b1, 5'd7, 32'h5555, 1'b1, 1'b0, 5'd8, 32'h0);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd8, 32'h0);
      #1;
      check("rd8 oDbgAck",   32'(oDbgAck), 32'h1);
      check("rd8 oDbgRData", oDbgRData,    32'h108);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd8, 32'h0);
      step();
      step();

      // Reset asserted in PEND with the CPU blocking a debug write to r12.
      drive(1'b1, 5'd1, 32'h3000, 1'b1, 1'b1, 5'd12, 32'hC0C0);
      step();
      step();
      step();
      #2;
      iCpuReset = 1'b0;
      #1;
      check("rst oDbgAck",   32'(oDbgAck),   32'h0);
      check("rst oCpuStall", 32'(oCpuStall), 32'h0);
      check("rst oDbgRData", oDbgRData,      32'h0);
      check("rst oRfRdAddr", 32'(oRfRdAddr), 32'h0);
      check("rst oRfWrAddr", 32'(oRfWrAddr), 32'h1);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd12, 32'hC0C0);
      step();
      step();
      iCpuReset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         #1;
         check($sformatf("post-rst%0d oRfWrEn", k), 32'(oRfWrEn), 32'h0);
         check($sformatf("post-rst%0d oDbgAck", k), 32'(oDbgAck), 32'h0);
      end
      check("post-rst r12 untouched", rf[12], 32'h10C);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
